uart_rx_fifo: RTL and testbench

- Receive-side byte buffer between the UART receiver's byte strobe and the CPU's UART read path, which is the 32-bit zero-extended input of the result mux.
- Absorbs bursts of received bytes while the CPU is stalled or busy.
- Hands bytes out one per read request, in arrival order.
- Reports empty/full/fill level and sticky error flags for polling by software.

---
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver byte strobe
// and the CPU read path. It is a circular buffer with a separate fill counter.
// Each read pops one byte and presents it zero-extended to 32 bits, and the
// sticky overflow and underflow flags can be polled by software.
// Optional feature macro: UART_RX_FIFO_IRQ_EN adds the IRQ_LEVEL parameter and
// a registered irq output. The irq output is high when the fill level reaches
// IRQ_LEVEL or when overflow is set.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  parameter int IRQ_LEVEL = 8
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rd_en,
  input  logic              clear,
  output logic [31:0]       data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_accept;
  logic              wr_accept;
  logic              wr_drop;
  logic              flush;

  // Accept and drop decisions. A read frees a slot in the same edge, so a
  // full FIFO can still take a write when a read is also accepted. A flush
  // swallows any strobe or request that arrives with it.
  always_comb begin
    flush     = reset | clear;
    rd_accept = rd_en & (count != '0) & ~flush;
    wr_accept = rx_valid & ((count != DEPTH_C) | rd_accept) & ~flush;
    wr_drop   = rx_valid & (count == DEPTH_C) & ~rd_accept & ~flush;
  end

  // Storage array written without reset so that it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Pointers, fill level, read data register and sticky flags.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_valid <= rd_accept;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= 32'(mem[rd_ptr]);
      end
      if (wr_accept && !rd_accept) begin
        count <= count + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count <= count - 1'b1;
      end
      if (wr_drop) begin
        overflow <= 1'b1;
      end
      if (rd_en && count == '0) begin
        underflow <= 1'b1;
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [ADDR_W:0] IRQ_LEVEL_C = (ADDR_W + 1)'(IRQ_LEVEL);

  // Interrupt request, registered one cycle behind the level and overflow state.
  always_ff @(posedge clock) begin
    if (flush) begin
      irq <= 1'b0;
    end else begin
      irq <= (count >= IRQ_LEVEL_C) | overflow;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a
// queue-based reference model of the byte buffer.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int IRQ_L = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
`ifdef UART_RX_FIFO_IRQ_EN
  logic        irq;
`endif

  uart_rx_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rd_en     (rd_en),
    .clear     (clear),
    .data_out  (data_out),
    .data_valid(data_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored bytes plus expected output registers.
  logic [7:0]  q [$];
  logic [31:0] m_data = '0;
  bit          m_dv = 0;
  bit          m_ovf = 0;
  bit          m_udf = 0;
  bit          m_irq = 0;

  task automatic model_flush();
    q.delete();
    m_data = '0;
    m_dv   = 0;
    m_ovf  = 0;
    m_udf  = 0;
    m_irq  = 0;
  endtask

  // Apply one cycle of stimulus, clock it, and advance the model.
  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c);
    bit irq_next;
    rx_valid = v;
    rx_data  = d;
    rd_en    = r;
    clear    = c;
    @(posedge clock);
    #1;
    irq_next = (q.size() >= IRQ_L) || m_ovf;
    if (c) begin
      model_flush();
    end else begin
      m_irq = irq_next;
      m_dv  = 0;
      if (r) begin
        if (q.size() > 0) begin
          m_data = {24'b0, q.pop_front()};
          m_dv   = 1;
        end else begin
          m_udf = 1;
        end
      end
      if (v) begin
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1;
      end
    end
    rx_valid = 0;
    rd_en    = 0;
    clear    = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    model_flush();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || data_out !== 32'd0 ||
        overflow !== 1'b0 || underflow !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d data_out=%h ovf=%b udf=%b dv=%b, required 1 0 0 0 0 0 0",
               empty, full, count, data_out, overflow, underflow, data_valid);
    end
    $display("reset: empty=%b count=%0d", empty, count);
  endtask

  task automatic test_in_order();
    logic [7:0] bytes [3] = '{8'h41, 8'h42, 8'h43};
    do_reset();
    for (int i = 0; i < 3; i++) step(1, bytes[i], 0, 0);
    checks++;
    if (count !== 5'd3) begin
      errors++;
      $display("FAIL inorder_count3: count=%0d required 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (data_out !== {24'b0, bytes[i]} || data_valid !== 1'b1 || count !== 5'(2 - i)) begin
        errors++;
        $display("FAIL inorder_read%0d: data_out=%h dv=%b count=%0d required %h 1 %0d",
                 i, data_out, data_valid, count, {24'b0, bytes[i]}, 2 - i);
      end
      $display("read %0d: data_out=%h count=%0d", i, data_out, count);
    end
    step(0, 0, 0, 0);
    checks++;
    if (data_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL inorder_end: dv=%b empty=%b required 0 1", data_valid, empty);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill16: full=%b count=%0d ovf=%b required 1 16 0", full, count, overflow);
    end
    step(1, 8'hAA, 0, 0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_drop: ovf=%b count=%0d required 1 16", overflow, count);
    end
    $display("overflow: ovf=%b count=%0d", overflow, count);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (data_out !== 32'(i) || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain%0d: data_out=%h dv=%b required %h 1", i, data_out, data_valid, 32'(i));
      end
    end
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: empty=%b ovf=%b required 1 1", empty, overflow);
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] oldest;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      step(1, b, 0, 0);
    end
    oldest = q[0];
    step(1, 8'h55, 1, 0);
    checks++;
    if (data_out !== {24'b0, oldest} || count !== 5'd16 || overflow !== 1'b0 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_simul: data_out=%h count=%0d ovf=%b dv=%b required %h 16 0 1",
               data_out, count, overflow, data_valid, {24'b0, oldest});
    end
    $display("full simul: data_out=%h count=%0d", data_out, count);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (data_out !== m_data) begin
        errors++;
        $display("FAIL full_simul_drain%0d: data_out=%h required %h", i, data_out, m_data);
      end
    end
    checks++;
    if (data_out !== 32'h55) begin
      errors++;
      $display("FAIL full_simul_last: data_out=%h required 00000055", data_out);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1, 8'h33, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    checks++;
    if (underflow !== 1'b1 || data_valid !== 1'b0 || data_out !== 32'h33) begin
      errors++;
      $display("FAIL underflow: udf=%b dv=%b data_out=%h required 1 0 00000033",
               underflow, data_valid, data_out);
    end
    step(1, 8'h7E, 1, 0);
    checks++;
    if (count !== 5'd1 || data_valid !== 1'b0 || underflow !== 1'b1 || data_out !== 32'h33) begin
      errors++;
      $display("FAIL empty_simul: count=%0d dv=%b udf=%b data_out=%h required 1 0 1 00000033",
               count, data_valid, underflow, data_out);
    end
    step(0, 0, 1, 0);
    checks++;
    if (data_out !== 32'h7E || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL empty_simul_read: data_out=%h dv=%b required 0000007e 1", data_out, data_valid);
    end
    $display("underflow: udf=%b data_out=%h", underflow, data_out);
  endtask

  task automatic test_wrap_clear();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      step(1, b, 0, 0);
      step(0, 0, 1, 0);
      checks++;
      if (data_out !== {24'b0, b}) begin
        errors++;
        $display("FAIL wrap%0d: data_out=%h required %h", i, data_out, {24'b0, b});
      end
    end
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
`ifdef UART_RX_FIFO_IRQ_EN
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b required 0", irq);
    end
    step(0, 0, 0, 0);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_level: irq=%b required 1", irq);
    end
`endif
    step(1, 8'hEE, 0, 1);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
        data_out !== 32'd0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear: count=%0d empty=%b ovf=%b udf=%b data_out=%h dv=%b required 0 1 0 0 0 0",
               count, empty, overflow, underflow, data_out, data_valid);
    end
`ifdef UART_RX_FIFO_IRQ_EN
    step(0, 0, 0, 0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b required 0", irq);
    end
`endif
    $display("clear: count=%0d empty=%b", count, empty);
  endtask

  task automatic test_random();
    bit v, r, c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 999) < 5);
      step(v, 8'($urandom), r, c);
      checks++;
      if (data_out !== m_data || data_valid !== m_dv || count !== 5'(q.size()) ||
          empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          overflow !== m_ovf || underflow !== m_udf
`ifdef UART_RX_FIFO_IRQ_EN
          || irq !== m_irq
`endif
         ) begin
        errors++;
        $display("FAIL random%0d: data_out=%h dv=%b count=%0d ovf=%b udf=%b required %h %b %0d %b %b",
                 i, data_out, data_valid, count, overflow, underflow,
                 m_data, m_dv, q.size(), m_ovf, m_udf);
      end
    end
    $display("random: final count=%0d", count);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_fill_overflow();
    test_full_simul();
    test_underflow();
    test_wrap_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
